// File: rtl/seven_seg_pkg.sv
// Shared constants for the hex seven-segment decoder.
// Patterns are active-high, bit order abcdefg (bit6=a .. bit0=g).
package seven_seg_pkg;

    typedef logic [6:0] seg_t;

    localparam int SEG_A = 6;
    localparam int SEG_B = 5;
    localparam int SEG_C = 4;
    localparam int SEG_D = 3;
    localparam int SEG_E = 2;
    localparam int SEG_F = 1;
    localparam int SEG_G = 0;

    localparam seg_t SEG_BLANK = 7'b0000000;
    localparam seg_t SEG_ALL   = 7'b1111111;

    localparam seg_t SEG_LUT [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

endpackage

// File: rtl/hex_to_seg_lut.sv
// Combinational nibble to active-high segment pattern lookup.
module hex_to_seg_lut
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] pattern
);

    always_comb begin
        pattern = SEG_LUT[nibble];
    end

endmodule

// File: rtl/seven_segment_display.sv
// Registered hex digit driver with lamp test, blanking and polarity select.
module seven_segment_display
    import seven_seg_pkg::*;
#(
    parameter bit ACTIVE_LOW_SEG = 1'b0
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [3:0] i_nibble,
    input  logic       i_blank,
    input  logic       i_lamp_test,
    output logic [6:0] o_segments
);

    localparam seg_t RST_VAL = ACTIVE_LOW_SEG ? ~SEG_BLANK : SEG_BLANK;

    seg_t lut_pat;
    seg_t sel_pat;
    seg_t seg_next;
    seg_t seg_q;

    hex_to_seg_lut u_lut (
        .nibble  (i_nibble),
        .pattern (lut_pat)
    );

    // Lamp test wins over blank so a dark digit can still be checked.
    always_comb begin
        sel_pat = lut_pat;
        if (i_lamp_test) begin
            sel_pat = SEG_ALL;
        end else if (i_blank) begin
            sel_pat = SEG_BLANK;
        end
        seg_next = ACTIVE_LOW_SEG ? ~sel_pat : sel_pat;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            seg_q <= RST_VAL;
        end else begin
            seg_q <= seg_next;
        end
    end

    assign o_segments = seg_q;

endmodule

// File: tb/tb_seven_segment_display.sv
// Scoreboard bench: common-cathode and common-anode instances side by side.
module tb_seven_segment_display;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] nibble;
    logic       blank;
    logic       lamp;
    logic [6:0] seg_hi;
    logic [6:0] seg_lo;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string      name;
        logic [6:0] exp_hi;
        logic [6:0] exp_lo;
    } exp_t;

    exp_t sb[$];
    exp_t cur;

    logic [6:0] tbl [16];

    always #5 clk = ~clk;

    seven_segment_display #(.ACTIVE_LOW_SEG(1'b0)) dut_hi (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_nibble    (nibble),
        .i_blank     (blank),
        .i_lamp_test (lamp),
        .o_segments  (seg_hi)
    );

    seven_segment_display #(.ACTIVE_LOW_SEG(1'b1)) dut_lo (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_nibble    (nibble),
        .i_blank     (blank),
        .i_lamp_test (lamp),
        .o_segments  (seg_lo)
    );

    // Inputs change on negedge; the result is due just after the next posedge.
    task automatic drive(input bit r, input logic [3:0] n, input bit b,
                         input bit l, input logic [6:0] eh,
                         input logic [6:0] el, input string nm);
        exp_t e;
        @(negedge clk);
        rst_n  = r;
        nibble = n;
        blank  = b;
        lamp   = l;
        e.name   = nm;
        e.exp_hi = eh;
        e.exp_lo = el;
        sb.push_back(e);
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            cur = sb.pop_front();
            total++;
            if (seg_hi !== cur.exp_hi) begin
                bad++;
                $display("FAIL %s cc: got %b want %b",
                         cur.name, seg_hi, cur.exp_hi);
            end
            total++;
            if (seg_lo !== cur.exp_lo) begin
                bad++;
                $display("FAIL %s ca: got %b want %b",
                         cur.name, seg_lo, cur.exp_lo);
            end
        end
    end

    initial begin
        tbl[0]  = 7'b1111110; tbl[1]  = 7'b0110000;
        tbl[2]  = 7'b1101101; tbl[3]  = 7'b1111001;
        tbl[4]  = 7'b0110011; tbl[5]  = 7'b1011011;
        tbl[6]  = 7'b1011111; tbl[7]  = 7'b1110000;
        tbl[8]  = 7'b1111111; tbl[9]  = 7'b1111011;
        tbl[10] = 7'b1110111; tbl[11] = 7'b0011111;
        tbl[12] = 7'b1001110; tbl[13] = 7'b0111101;
        tbl[14] = 7'b1001111; tbl[15] = 7'b1000111;

        rst_n  = 1'b0;
        nibble = 4'h8;
        blank  = 1'b0;
        lamp   = 1'b0;

        drive(0, 4'h8, 0, 0, 7'b0000000, 7'b1111111, "rst0");
        drive(0, 4'h8, 0, 0, 7'b0000000, 7'b1111111, "rst1");
        drive(1, 4'h8, 0, 0, 7'b1111111, 7'b0000000, "rel");

        for (int i = 0; i < 16; i++) begin
            drive(1, 4'(i), 0, 0, tbl[i], ~tbl[i], $sformatf("hex%0h", i));
        end

        drive(1, 4'h0, 0, 0, 7'b1111110, 7'b0000001, "ca0");
        drive(1, 4'h1, 0, 0, 7'b0110000, 7'b1001111, "ca1");

        drive(1, 4'h3, 1, 0, 7'b0000000, 7'b1111111, "blank");
        drive(1, 4'h3, 1, 1, 7'b1111111, 7'b0000000, "lamp");
        drive(1, 4'h3, 0, 1, 7'b1111111, 7'b0000000, "lamp_only");
        drive(1, 4'h3, 0, 0, 7'b1111001, 7'b0000110, "resume3");
        drive(1, 4'h3, 0, 0, 7'b1111001, 7'b0000110, "hold3");

        drive(1, 4'h2, 0, 0, 7'b1101101, 7'b0010010, "lat2");
        drive(1, 4'h5, 0, 0, 7'b1011011, 7'b0100100, "lat5");
        drive(0, 4'h5, 0, 1, 7'b0000000, 7'b1111111, "midrst");
        drive(1, 4'hA, 0, 0, 7'b1110111, 7'b0001000, "after_rst");

        for (int k = 0; k < 20 && sb.size() != 0; k++) begin
            @(posedge clk);
        end
        #2;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d left want 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
